dds_sweep_ctrl: RTL and testbench

Sequencer that drives the DDS phase-accumulator core's frequency word `k`, phase offset `p` and enable `en` to produce a linear frequency sweep. It accepts one sweep command through a valid/ready handshake, then steps `k` from a start word by a fixed increment. Each step dwells for a programmable number of clocks. It sits between the host/config logic and the DDS core, whose `k`/`p`/`en` inputs it owns exclusively.

---
 rtl/dds_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Purpose  : Linear frequency-sweep sequencer for a DDS phase-accumulator core.
//            It takes one sweep command over a valid/ready handshake, then steps
//            the frequency word k from a start value by a fixed increment. Each
//            step dwells for (dwell+1) clocks.
// Options  : DDS_SWEEP_BIDIR_EN - after the peak step, sweep back down to the
//            start word before finishing (adds the DOWN state).
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 12,
  parameter int NW = 16,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [KW-1:0] cmd_k_start,
  input  logic [KW-1:0] cmd_k_step,
  input  logic [NW-1:0] cmd_n_steps,
  input  logic [DW-1:0] cmd_dwell,
  input  logic [PW-1:0] cmd_phase,
  input  logic          abort,
  output logic [KW-1:0] k,
  output logic [PW-1:0] p,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] step_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
`ifdef DDS_SWEEP_BIDIR_EN
  localparam logic [1:0] S_DOWN = 2'd3;
`endif

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [KW-1:0] r_k_step;
  logic [NW-1:0] r_n_steps;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] r_cnt;
  logic          w_term;
  logic          w_last;
  logic          w_sweeping;

  // End of the current step's dwell, and whether this is the peak step.
  assign w_term = (r_cnt == r_dwell);
  assign w_last = (step_idx == r_n_steps);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort beats every other transition outside IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_term && w_last) begin
`ifdef DDS_SWEEP_BIDIR_EN
          // A zero-step sweep has no downward leg.
          w_next = (r_n_steps != '0) ? S_DOWN : S_FIN;
`else
          w_next = S_FIN;
`endif
        end
      end
`ifdef DDS_SWEEP_BIDIR_EN
      S_DOWN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_term && (step_idx == '0)) begin
          w_next = S_FIN;
        end
      end
`endif
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode: only cmd_ready is combinational, everything else is registered.
  always_comb begin
    cmd_ready  = (r_state == S_IDLE);
`ifdef DDS_SWEEP_BIDIR_EN
    w_sweeping = (w_next == S_RUN) || (w_next == S_DOWN);
`else
    w_sweeping = (w_next == S_RUN);
`endif
  end

  // Status flags registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      en   <= w_sweeping;
      busy <= w_sweeping;
      done <= (w_next == S_FIN);
    end
  end

  // Command capture, dwell counting and frequency-word stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      p         <= '0;
      step_idx  <= '0;
      r_cnt     <= '0;
      r_k_step  <= '0;
      r_n_steps <= '0;
      r_dwell   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            k         <= cmd_k_start;
            p         <= cmd_phase;
            step_idx  <= '0;
            r_cnt     <= '0;
            r_k_step  <= cmd_k_step;
            r_n_steps <= cmd_n_steps;
            r_dwell   <= cmd_dwell;
          end
        end
        S_RUN: begin
          if (!abort) begin
            if (w_term) begin
              r_cnt <= '0;
              if (!w_last) begin
                k        <= k + r_k_step;
                step_idx <= step_idx + 1'b1;
              end
`ifdef DDS_SWEEP_BIDIR_EN
              // Peak step already played once; first downward step is one below.
              else if (r_n_steps != '0) begin
                k        <= k - r_k_step;
                step_idx <= step_idx - 1'b1;
              end
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`ifdef DDS_SWEEP_BIDIR_EN
        S_DOWN: begin
          if (!abort) begin
            if (w_term) begin
              r_cnt <= '0;
              if (step_idx != '0) begin
                k        <= k - r_k_step;
                step_idx <= step_idx - 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Purpose  : Self-checking bench for dds_sweep_ctrl. A timeline model predicts
//            every output from the time elapsed since command acceptance;
//            directed sweeps add hand-computed literal expectations.
//            Build with DDS_SWEEP_BIDIR_EN to also exercise the up/down sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

  localparam int KW = 32;
  localparam int PW = 12;
  localparam int NW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k_start = '0;
  logic [KW-1:0] cmd_k_step = '0;
  logic [NW-1:0] cmd_n_steps = '0;
  logic [DW-1:0] cmd_dwell = '0;
  logic [PW-1:0] cmd_phase = '0;
  logic          abort = 1'b0;
  logic [KW-1:0] k;
  logic [PW-1:0] p;
  logic          en;
  logic          busy;
  logic          done;
  logic [NW-1:0] step_idx;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  dds_sweep_ctrl #(.KW(KW), .PW(PW), .NW(NW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_k_start(cmd_k_start),
    .cmd_k_step (cmd_k_step),
    .cmd_n_steps(cmd_n_steps),
    .cmd_dwell  (cmd_dwell),
    .cmd_phase  (cmd_phase),
    .abort      (abort),
    .k          (k),
    .p          (p),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_t counts cycles since acceptance (1 = first sweep cycle).
  logic            m_active = 1'b0;
  longint unsigned m_t = 0;
  longint unsigned m_start = 0, m_step = 0, m_n = 0, m_d = 0;
  logic [PW-1:0]   m_p = '0;
  logic [KW-1:0]   m_hold_k = '0;
  logic [NW-1:0]   m_hold_idx = '0;

  function automatic longint unsigned run_len();
`ifdef DDS_SWEEP_BIDIR_EN
    return (2 * m_n + 1) * (m_d + 1);
`else
    return (m_n + 1) * (m_d + 1);
`endif
  endfunction

  function automatic longint unsigned idx_at(input longint unsigned t);
    longint unsigned s;
    s = (t - 1) / (m_d + 1);
`ifdef DDS_SWEEP_BIDIR_EN
    if (s > m_n) s = 2 * m_n - s;
`endif
    return s;
  endfunction

  function automatic logic [KW-1:0] k_at(input longint unsigned t);
    longint unsigned v;
    v = m_start + idx_at(t) * m_step;
    return v[KW-1:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   <= 1'b0;
      m_t        <= 0;
      m_p        <= '0;
      m_hold_k   <= '0;
      m_hold_idx <= '0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_start  <= longint'(cmd_k_start);
        m_step   <= longint'(cmd_k_step);
        m_n      <= longint'(cmd_n_steps);
        m_d      <= longint'(cmd_dwell);
        m_p      <= cmd_phase;
      end
    end else if (abort || (m_t >= run_len() + 1)) begin
      m_active   <= 1'b0;
      m_hold_k   <= k_at((m_t > run_len()) ? run_len() : m_t);
      m_hold_idx <= NW'(idx_at((m_t > run_len()) ? run_len() : m_t));
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Compare every cycle outside reset.
  always @(negedge clk) begin
    logic [KW-1:0] ek;
    logic [NW-1:0] ei;
    logic          e_en, e_done, e_rdy;
    if (!rst) begin
      if (m_active && (m_t <= run_len())) begin
        ek = k_at(m_t); ei = NW'(idx_at(m_t)); e_en = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
      end else if (m_active) begin
        ek = k_at(run_len()); ei = NW'(idx_at(run_len())); e_en = 1'b0; e_done = 1'b1; e_rdy = 1'b0;
      end else begin
        ek = m_hold_k; ei = m_hold_idx; e_en = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
      end
      chk("m_k", k, ek);
      chk("m_p", p, m_p);
      chk("m_step_idx", step_idx, ei);
      chk("m_en", en, e_en);
      chk("m_busy", busy, e_en);
      chk("m_done", done, e_done);
      chk("m_cmd_ready", cmd_ready, e_rdy);
      if (en) en_cnt++;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [KW-1:0] s, input logic [KW-1:0] st, input logic [NW-1:0] n,
                      input logic [DW-1:0] d, input logic [PW-1:0] ph);
    cmd_k_start = s;
    cmd_k_step  = st;
    cmd_n_steps = n;
    cmd_dwell   = d;
    cmd_phase   = ph;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int max);
    int c;
    c = 0;
    while (c < max) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [KW-1:0] bexp [5];

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_k", k, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_en", en, 0);

    // Basic 4-step sweep, 5 cycles per step
    align();
    en_cnt = 0; done_cnt = 0;
    send(32'h0010_0000, 32'h0001_0000, 16'd3, 24'd4, 12'h000);
    wait_neg(1);
    chk("t1_k_step0", k, 32'h0010_0000);
    wait_neg(5);
    chk("t1_k_step1", k, 32'h0011_0000);
    wait_neg(10);
    chk("t1_k_step3", k, 32'h0013_0000);
    wait_done(100);
    chk("t1_fin_ready", cmd_ready, 0);
    chk("t1_fin_en", en, 0);
    wait_neg(1);
    chk("t1_ready_back", cmd_ready, 1);
    chk("t1_en_cycles", en_cnt, 20);
    chk("t1_done_pulses", done_cnt, 1);

    // Single tone, one cycle
    align();
    en_cnt = 0; done_cnt = 0;
    send(32'h0000_5000, 32'h1, 16'd0, 24'd0, 12'h3FF);
    wait_neg(1);
    chk("t2_en", en, 1);
    chk("t2_p", p, 12'h3FF);
    wait_neg(1);
    chk("t2_done", done, 1);
    chk("t2_en_off", en, 0);
    wait_neg(1);
    chk("t2_en_cycles", en_cnt, 1);

    // Wrap-around of the frequency word
    align();
    send(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 24'd1, 12'h055);
    wait_neg(1);
    chk("t3_k0", k, 32'hFFFF_FFF0);
    wait_neg(2);
    chk("t3_k1", k, 32'h0000_0010);
    wait_neg(2);
    chk("t3_k2", k, 32'h0000_0030);
    wait_done(50);

    // Abort on the 3rd cycle of step 1, then immediate new command
    align();
    en_cnt = 0; done_cnt = 0;
    send(32'h0000_1000, 32'h0000_0100, 16'd5, 24'd4, 12'h0AA);
    repeat (7) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    chk("t4_en_off", en, 0);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_k_hold", k, 32'h0000_1100);
    chk("t4_idx_hold", step_idx, 1);
    chk("t4_en_cycles", en_cnt, 8);
    chk("t4_no_done", done_cnt, 0);
    send(32'h0000_2000, 32'h0000_0010, 16'd1, 24'd1, 12'h123);
    wait_neg(1);
    chk("t4_new_k", k, 32'h0000_2000);
    chk("t4_new_en", en, 1);
    wait_done(50);

    // cmd_valid held during sweep, then async reset mid-sweep
    align();
    send(32'h0000_4000, 32'h0000_0040, 16'd2, 24'd2, 12'h001);
    cmd_k_start = 32'hDEAD_0000;
    cmd_k_step  = 32'h0000_0001;
    cmd_n_steps = 16'd4;
    cmd_dwell   = 24'd3;
    cmd_phase   = 12'hABC;
    cmd_valid   = 1'b1;
    wait_neg(1);
    chk("t5_ignored_k", k, 32'h0000_4000);
    wait_done(50);
    align();
    align();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_held_k", k, 32'hDEAD_0000);
    chk("t5_held_p", p, 12'hABC);
    wait_neg(3);
    @(posedge clk);
    #3 rst = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("t5_rst_k", k, 0);
    chk("t5_rst_p", p, 0);
    chk("t5_rst_en", en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_idx", step_idx, 0);
    chk("t5_rst_ready", cmd_ready, 1);
    @(posedge clk);
    #2;
    chk("t5_rst_no_accept", en, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst_k", k, 0);

`ifdef DDS_SWEEP_BIDIR_EN
    // Up/down sweep
    bexp[0] = 32'h100; bexp[1] = 32'h200; bexp[2] = 32'h300;
    bexp[3] = 32'h200; bexp[4] = 32'h100;
    align();
    en_cnt = 0; done_cnt = 0;
    send(32'h0000_0100, 32'h0000_0100, 16'd2, 24'd0, 12'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_k", k, bexp[i]);
    end
    @(negedge clk);
    chk("t6_done", done, 1);
    @(negedge clk);
    chk("t6_en_cycles", en_cnt, 5);
`else
    bexp[0] = 32'h0;
    if (bexp[0] != 32'h0) $display("unreachable");
`endif

    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
